// File: rtl/temp_report_sched_pkg.sv
// Shared types and frame constants for the periodic temperature report scheduler.
package temp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    SEND
  } state_t;

  localparam logic [7:0] CHAR_T  = 8'h54;
  localparam logic [7:0] CHAR_E  = 8'h45;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam int         FRAME_LEN = 6;

endpackage

// File: rtl/temp_report_sched_if.sv
// Measurement request/result and UART TX byte handshake between the scheduler and its neighbours.
interface temp_report_sched_if;

  logic        meas_start;
  logic        meas_done;
  logic [11:0] meas_value;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport master (
    output meas_start,
    input  meas_done,
    input  meas_value,
    output tx_valid,
    input  tx_ready,
    output tx_data
  );

  modport slave (
    input  meas_start,
    output meas_done,
    output meas_value,
    input  tx_valid,
    output tx_ready,
    input  tx_data
  );

endinterface

// File: rtl/temp_report_sched_hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/temp_report_sched.sv
// Paces temperature measurements, waits for each result under a timeout and
// streams it to the UART TX as a 6-byte ASCII frame: marker, three hex digits, CR, LF.
module temp_report_sched
  import temp_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 1_000_000,
  parameter int TIMEOUT_CYCLES = 65_536
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                force_req,
  temp_report_sched_if.master bus,
  output logic                busy,
  output logic                timeout_o
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    BYTE_LAST    = 3'(FRAME_LEN - 1);

  state_t        state, state_next;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] wait_cnt;
  logic          pending;
  logic [11:0]   value_q;
  logic          is_err;
  logic [2:0]    byte_idx;
  logic          period_wrap;
  logic          wait_expired;
  logic          handshake;
  logic [3:0]    nibble;
  logic [7:0]    hex_char;

  assign period_wrap  = enable && (period_cnt == PERIOD_LAST);
  assign wait_expired = (state == WAIT) && !bus.meas_done && (wait_cnt == TIMEOUT_LAST);
  assign handshake    = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        period_cnt <= '0;
    else if (!enable || period_wrap)  period_cnt <= '0;
    else                              period_cnt <= period_cnt + 1'b1;
  end

  // A new request beats the clear in START so no request is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      pending <= 1'b0;
    else if (enable && (period_wrap || force_req))  pending <= 1'b1;
    else if (state == START)                        pending <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (bus.meas_done || wait_expired) state_next = SEND;
      SEND:    if (handshake && (byte_idx == BYTE_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      value_q  <= '0;
      is_err   <= 1'b0;
      byte_idx <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if ((state == WAIT) && bus.meas_done) begin
        value_q <= bus.meas_value;
        is_err  <= 1'b0;
      end else if (wait_expired) begin
        value_q <= 12'hFFF;
        is_err  <= 1'b1;
      end
      if (state != SEND)                             byte_idx <= '0;
      else if (handshake && (byte_idx == BYTE_LAST)) byte_idx <= '0;
      else if (handshake)                            byte_idx <= byte_idx + 3'd1;
    end
  end

  always_comb begin
    case (byte_idx)
      3'd1:    nibble = value_q[11:8];
      3'd2:    nibble = value_q[7:4];
      3'd3:    nibble = value_q[3:0];
      default: nibble = 4'h0;
    endcase
  end

  hex_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    bus.tx_data = 8'h00;
    if (state == SEND) begin
      case (byte_idx)
        3'd0:             bus.tx_data = is_err ? CHAR_E : CHAR_T;
        3'd1, 3'd2, 3'd3: bus.tx_data = hex_char;
        3'd4:             bus.tx_data = CHAR_CR;
        default:          bus.tx_data = CHAR_LF;
      endcase
    end
  end

  assign bus.meas_start = (state == START);
  assign bus.tx_valid   = (state == SEND);
  assign busy           = (state != IDLE);
  assign timeout_o      = wait_expired;

endmodule

// File: tb/tb_temp_report_sched.sv
// Randomised self-checking bench: a measurement responder and a byte scoreboard model the frame stream.
module tb_temp_report_sched;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic force_req = 1'b0;
  logic busy;
  logic timeout_o;

  temp_report_sched_if ifc ();

  temp_report_sched #(
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .force_req (force_req),
    .bus       (ifc),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_bytes[$];
  int starts[$];
  int exp_to_cycle = -1;
  int to_count = 0;
  int hs_count = 0;
  int valid_cycles = 0;
  int resp_mode = 1;
  logic [11:0] fixed_value = 12'h000;
  int fixed_delay = 5;
  int ready_mode = 0;
  bit rdy_level = 1'b1;
  string hex_digits = "0123456789ABCDEF";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic pushFrame(input bit err, input logic [11:0] v);
    logic [7:0] c;
    exp_bytes.push_back(err ? 8'h45 : 8'h54);
    for (int i = 2; i >= 0; i--) begin
      c = hex_digits[v[i*4 +: 4]];
      exp_bytes.push_back(c);
    end
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input int rmode, input bit rlevel);
    enable = en;
    ready_mode = rmode;
    rdy_level = rlevel;
  endtask

  task automatic pulseForce();
    force_req = 1'b1;
    tick(1);
    force_req = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_meas_start"}, 32'(ifc.meas_start), 0);
    checkOutput({tag, "_tx_valid"}, 32'(ifc.tx_valid), 0);
    checkOutput({tag, "_tx_data"}, 32'(ifc.tx_data), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_timeout_o"}, 32'(timeout_o), 0);
  endtask

  task automatic drainIdle(input string tag, input int budget);
    int n = 0;
    tick(3);
    while ((busy || exp_bytes.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(busy || exp_bytes.size() != 0), 0);
  endtask

  task automatic waitStart(input string tag, input int prev, input int budget);
    int n = 0;
    while (starts.size() <= prev && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_start_seen"}, 32'(starts.size() > prev), 1);
  endtask

  // UART side: ready pattern chosen by the running scenario.
  initial begin
    ifc.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ifc.tx_ready = rdy_level;
        1:       ifc.tx_ready = ~ifc.tx_ready;
        default: ifc.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Measurement unit model; each accepted start defines the frame that must follow.
  initial begin
    logic [11:0] v;
    int k;
    bit resp;
    ifc.meas_done = 1'b0;
    ifc.meas_value = 12'h5A5;
    forever begin
      @(negedge clk);
      if (!reset && ifc.meas_start) begin
        case (resp_mode)
          0: begin
            resp = ($urandom_range(0, 4) != 0);
            v = 12'($urandom);
            k = $urandom_range(1, TIMEOUT);
          end
          1: begin
            resp = 1'b1;
            v = fixed_value;
            k = fixed_delay;
          end
          default: begin
            resp = 1'b0;
            v = 12'h000;
            k = 0;
          end
        endcase
        pushFrame(!resp, resp ? v : 12'hFFF);
        if (!resp) exp_to_cycle = cyc + TIMEOUT;
        else begin
          repeat (k) @(posedge clk);
          #1;
          ifc.meas_done = 1'b1;
          ifc.meas_value = v;
          @(posedge clk);
          #1;
          ifc.meas_done = 1'b0;
          ifc.meas_value = 12'($urandom);
          @(negedge clk);
          checkOutput("done_to_valid", 32'(ifc.tx_valid), 1);
        end
      end
    end
  end

  bit held = 1'b0;
  logic [7:0] held_data = 8'h00;

  always @(negedge clk) begin
    if (reset) held = 1'b0;
    else begin
      if (ifc.meas_start) starts.push_back(cyc);
      if (timeout_o) to_count++;
      if (timeout_o || cyc == exp_to_cycle)
        checkOutput("timeout_o", 32'(timeout_o), 32'(cyc == exp_to_cycle));
      if (ifc.tx_valid) valid_cycles++;
      if (held) begin
        checkOutput("tx_valid_hold", 32'(ifc.tx_valid), 1);
        checkOutput("tx_data_hold", 32'(ifc.tx_data), 32'(held_data));
      end
      if (ifc.tx_valid && ifc.tx_ready) begin
        hs_count++;
        checkOutput("tx_byte_expected", 32'(exp_bytes.size() != 0), 1);
        if (exp_bytes.size() != 0) checkOutput("tx_data", 32'(ifc.tx_data), 32'(exp_bytes.pop_front()));
        held = 1'b0;
      end else begin
        held = ifc.tx_valid;
        held_data = ifc.tx_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, h0, vc0, t0, n;

    tick(2);
    checkResetOutputs("reset");
    reset = 1'b0;
    tick(2);

    // Periodic reporting with a fixed result.
    starts.delete();
    resp_mode = 1;
    fixed_value = 12'h3A7;
    fixed_delay = 5;
    vc0 = valid_cycles;
    applyStimulus(1, 0, 1);
    tick(350);
    applyStimulus(0, 0, 1);
    drainIdle("periodic", 100);
    checkOutput("periodic_frames", starts.size(), 3);
    for (int i = 1; i < starts.size(); i++)
      checkOutput("periodic_interval", starts[i] - starts[i-1], PERIOD);
    checkOutput("periodic_valid_cycles", valid_cycles - vc0, 18);

    // Forced request with toggling backpressure.
    fixed_value = 12'h0F0;
    fixed_delay = 3;
    applyStimulus(1, 1, 0);
    force_req = 1'b1;
    tick(1);
    force_req = 1'b0;
    checkOutput("force_start_early", 32'(ifc.meas_start), 0);
    tick(1);
    checkOutput("force_start_latency", 32'(ifc.meas_start), 1);
    tick(1);
    n = 0;
    while (exp_bytes.size() != 0 && n < 80) begin
      checkOutput("force_busy", 32'(busy), 1);
      tick(1);
      n++;
    end
    applyStimulus(0, 0, 1);
    drainIdle("force", 100);

    // Measurement never answers.
    resp_mode = 2;
    t0 = to_count;
    applyStimulus(1, 0, 1);
    pulseForce();
    tick(5);
    applyStimulus(0, 0, 1);
    drainIdle("timeout", 100);
    checkOutput("timeout_pulses", to_count - t0, 1);

    // Several requests during a stalled SEND coalesce into one follow-up.
    resp_mode = 1;
    fixed_value = 12'h123;
    fixed_delay = 2;
    s0 = starts.size();
    applyStimulus(1, 0, 0);
    pulseForce();
    n = 0;
    while (!ifc.tx_valid && n < 30) begin
      tick(1);
      n++;
    end
    checkOutput("coalesce_in_send", 32'(ifc.tx_valid), 1);
    pulseForce();
    tick(1);
    pulseForce();
    tick(1);
    pulseForce();
    tick(5);
    rdy_level = 1'b1;
    tick(40);
    applyStimulus(0, 0, 1);
    drainIdle("coalesce", 100);
    checkOutput("coalesce_starts", starts.size() - s0, 2);

    // Asynchronous reset after the third byte is accepted.
    fixed_value = 12'hBEE;
    h0 = hs_count;
    applyStimulus(1, 0, 1);
    pulseForce();
    n = 0;
    while (hs_count < h0 + 3 && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("midreset_bytes_before", hs_count - h0, 3);
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    exp_bytes.delete();
    tick(2);
    reset = 1'b0;
    s0 = starts.size();
    vc0 = valid_cycles;
    tick(50);
    checkOutput("post_reset_starts", starts.size() - s0, 0);
    checkOutput("post_reset_valid", valid_cycles - vc0, 0);
    applyStimulus(0, 0, 1);
    drainIdle("midreset", 50);

    // Dropping enable lets an in-flight frame finish, then blocks all requests.
    fixed_value = 12'h9C4;
    fixed_delay = 4;
    s0 = starts.size();
    h0 = hs_count;
    applyStimulus(1, 0, 1);
    pulseForce();
    waitStart("inflight", s0, 20);
    applyStimulus(0, 0, 1);
    drainIdle("inflight", 100);
    checkOutput("inflight_bytes", hs_count - h0, 6);
    s0 = starts.size();
    for (int i = 0; i < 3 * PERIOD; i++) begin
      force_req = (i % 37 == 5);
      tick(1);
    end
    force_req = 1'b0;
    tick(3);
    checkOutput("disabled_starts", starts.size() - s0, 0);

    // Random traffic: requests, backpressure, result delays and timeouts.
    resp_mode = 0;
    s0 = starts.size();
    applyStimulus(1, 2, 1);
    for (int i = 0; i < 1500; i++) begin
      force_req = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    force_req = 1'b0;
    applyStimulus(0, 0, 1);
    drainIdle("random", 200);
    checkOutput("random_activity", 32'(starts.size() > s0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_report_sched.md
# temp_report_sched

Controller that sequences periodic temperature reporting in the UART temperature-sensor design. Paces measurements of the PWM temperature decoder with a programmable period, waits for each result under a timeout, then formats it as a 6-byte ASCII frame and pushes it byte by byte to the UART transmitter through a valid/ready handshake. Sits between the PWM measurement unit and the UART TX serializer inside `uart_temp`.

## Interface

Parameters:
- `PERIOD_CYCLES`, default 1_000_000: clock cycles between periodic measurement requests. Must be ≥ 2.
- `TIMEOUT_CYCLES`, default 65_536: maximum number of cycles spent waiting for `meas_done`. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level. High enables the periodic timer and `force_req`.
- `force_req`  in  1  single-cycle pulse. Requests an immediate measurement.
- `meas_start`  out  1  single-cycle pulse to the measurement unit.
- `meas_done`  in  1  single-cycle pulse. The measurement result is valid.
- `meas_value`  in  12  measurement result. Sampled only in the cycle `meas_done` is high.
- `tx_valid`  out  1  a byte is offered to the UART TX.
- `tx_ready`  in  1  the UART TX accepts the byte.
- `tx_data`  out  8  ASCII byte offered to the UART TX.
- `busy`  out  1  high in every state except IDLE.
- `timeout_o`  out  1  single-cycle pulse when a measurement times out.

## Operation

- Reset values: `meas_start`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `timeout_o`=0. On reset the state is IDLE, all counters are 0 and `pending` is 0.
- Period counter:
  - Runs while `enable`=1.
  - Wraps at `PERIOD_CYCLES`-1. On the wrap it sets `pending`.
  - When `enable`=0 the counter is held at 0.
- `force_req` sets `pending` only when `enable`=1.
- Requests coalesce: `pending` is a single flag, so multiple requests made while busy produce exactly one follow-up frame.
- If a request arrives in the same cycle that `pending` is cleared, the set wins.
- States:
  - IDLE: when `pending`=1, go to START.
  - START: one cycle. `meas_start`=1 and `pending` is cleared. Go to WAIT.
  - WAIT:
    - Timeout counter starts at 0 and increments each cycle.
    - If `meas_done` is high, latch `meas_value` and marker 'T' (0x54), then go to SEND.
    - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, latch value 12'hFFF and marker 'E' (0x45), pulse `timeout_o`, and go to SEND.
    - If `meas_done` and the timeout occur in the same cycle, `meas_done` wins.
  - SEND:
    - Byte index runs 0..5. The frame is: marker, hex digit of bits [11:8], hex digit of [7:4], hex digit of [3:0], CR (0x0D), LF (0x0A).
    - Hex digits are uppercase ASCII: 0–9 map to 0x30–0x39, A–F map to 0x41–0x46.
    - On `tx_valid` && `tx_ready` the index increments. The handshake on index 5 returns the block to IDLE.
- A `meas_done` pulse outside WAIT is ignored, including in the START cycle.
- Dropping `enable` never aborts a frame already in flight. The frame finishes normally.
- An asynchronous reset asserted mid-frame aborts it. Outputs return to their reset values immediately and no partial frame is resumed.

## Timing

- Request to `meas_start`:
  - `pending` is set at edge N. The block enters START at edge N+1, so `meas_start` is high in the cycle after `pending` is seen.
  - A request that arrives while the block is in IDLE therefore produces `meas_start` 2 cycles later.
- `meas_done` to first `tx_valid`: 1 cycle. The value is latched at the edge where `meas_done` is high, and `tx_valid` rises after that edge.
- While `tx_valid` is high, `tx_data` is stable and `tx_valid` does not drop until the handshake.
- Back-to-back bytes: after a handshake, `tx_valid` stays high with the next byte in the following cycle, giving no bubble.
- Minimum frame duration: 6 cycles with `tx_ready` held at 1.
- Back-to-back frames: the earliest START after the final LF handshake is the next cycle + 1, through IDLE.

## Structure

- Package `temp_sched_pkg` holds:
  - the state enum (IDLE, START, WAIT, SEND);
  - the constants `CHAR_T`, `CHAR_E`, `CHAR_CR`, `CHAR_LF`, and `FRAME_LEN`=6.
- Sub-module `hex_to_ascii`: combinational, 4-bit nibble in, 8-bit ASCII out. One instance is used, and its input is selected by the byte index.
- Everything else lives in a single module: the FSM, the period counter, the timeout counter, the `pending` flag, the value/marker latches and the byte index.

## Test plan

- Periodic report: `PERIOD_CYCLES`=100, `enable`=1, measurement model returns 12'h3A7 5 cycles after start, `tx_ready`=1 → every 100 cycles the bytes 0x54, 0x33, 0x41, 0x37, 0x0D, 0x0A are sent.
- Force request with backpressure: `force_req` pulse while IDLE, value 12'h0F0, `tx_ready` toggling 1/0 → `meas_start` is seen 2 cycles later; bytes "T0F0\r\n" are sent with `tx_data` stable while stalled; `busy` is high throughout.
- Timeout: `TIMEOUT_CYCLES`=16, no `meas_done` → `timeout_o` pulses exactly once, on the 16th WAIT cycle; frame "EFFF\r\n" is sent.
- Coalescing: 3 `force_req` pulses during a SEND with `tx_ready` held at 0 → exactly one further frame follows the current one.
- Reset mid-frame: assert `reset` after byte 2 has been accepted → all outputs are at reset values in the same cycle; after release no bytes are sent until a new request.
- Enable low: `enable`=0 for 3×`PERIOD_CYCLES`, `force_req` pulsed → `meas_start` never asserts; an in-flight frame started before the drop completes.
